// File: rtl/fp_addsub_norm_pipe.sv
// fp_addsub_norm_pipe: two-stage magnitude add/sub, normalise, round and pack.
// Stage1 adds/subtracts the aligned mantissas, swapping operands so the result is non-negative.
// Stage2 normalises and rounds the result, then packs it with its flags.
// Optional build macro FP_ADDSUB_RNE_EN: round-to-nearest-even (default build truncates).
module fp_addsub_norm_pipe #(
  parameter int unsigned E_WIDTH = 8,
  parameter int unsigned M_WIDTH = 23
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         op_sub,
  input  logic                         sign_a,
  input  logic [E_WIDTH-1:0]           exp_in,
  input  logic [M_WIDTH+3:0]           man_a,
  input  logic [M_WIDTH+3:0]           man_b,
  input  logic                         spc_case,
  input  logic [E_WIDTH+M_WIDTH:0]     spc_val,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [E_WIDTH+M_WIDTH:0]     result,
  output logic                         flag_ovf,
  output logic                         flag_unf,
  output logic                         flag_inexact
);

  localparam int unsigned MW    = M_WIDTH + 4;          // {hidden, fraction, G, R, S}
  localparam int unsigned RAW_W = M_WIDTH + 5;          // MW plus carry
  localparam int unsigned RW    = 1 + E_WIDTH + M_WIDTH;
  localparam int unsigned LZ_W  = $clog2(MW + 1);
  localparam int unsigned XE_W  = E_WIDTH + 2;          // signed exponent with headroom
  localparam logic signed [XE_W-1:0] EXP_MAX = XE_W'((1 << E_WIDTH) - 1);
`ifdef FP_ADDSUB_RNE_EN
  localparam int unsigned MR_W  = M_WIDTH + 2;          // hidden + fraction + rounding carry
`endif

  // Stage1 registers
  logic               s1_valid_q, s1_valid_d;
  logic [RAW_W-1:0]   s1_raw_q, s1_raw_d;
  logic               s1_sign_q, s1_sign_d;
  logic [E_WIDTH-1:0] s1_exp_q, s1_exp_d;
  logic               s1_spc_q, s1_spc_d;
  logic [RW-1:0]      s1_spc_val_q, s1_spc_val_d;

  // Stage2 (output) registers
  logic               s2_valid_q, s2_valid_d;
  logic [RW-1:0]      result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               inexact_q, inexact_d;

  // Stage1 combinational datapath
  logic [RAW_W-1:0]   raw_in;
  logic               sign_in;

  // Stage2 combinational datapath
  logic [LZ_W-1:0]        lz;
  logic [MW-1:0]          norm_man;
  logic signed [XE_W-1:0] exp_ext;
  logic signed [XE_W-1:0] exp_norm;
  logic signed [XE_W-1:0] exp_fin;
  logic [M_WIDTH-1:0]     frac;
  logic                   is_zero;
  logic [RW-1:0]          norm_result;
  logic                   norm_ovf;
  logic                   norm_unf;
  logic                   norm_inexact;
`ifdef FP_ADDSUB_RNE_EN
  logic                   round_inc;
  logic [MR_W-1:0]        mant_rnd;
`endif

  logic s2_adv;

  // Handshake: stage2 drains when downstream takes it or it is empty
  assign s2_adv   = out_ready | ~s2_valid_q;
  assign in_ready = ~s1_valid_q | s2_adv;

  assign out_valid    = s2_valid_q;
  assign result       = result_q;
  assign flag_ovf     = ovf_q;
  assign flag_unf     = unf_q;
  assign flag_inexact = inexact_q;

  // Magnitude add/subtract with operand swap so the difference is never negative
  always_comb begin
    raw_in  = RAW_W'(man_a) + RAW_W'(man_b);
    sign_in = sign_a;
    if (op_sub) begin
      if (man_b > man_a) begin
        raw_in  = RAW_W'(man_b - man_a);
        sign_in = ~sign_a;
      end else begin
        raw_in  = RAW_W'(man_a - man_b);
        sign_in = sign_a;
      end
    end
  end

  // Normalise, round and pack the stage1 result
  always_comb begin
    lz = LZ_W'(MW);
    for (int i = 0; i < int'(MW); i++) begin
      if (s1_raw_q[i]) lz = LZ_W'(MW - 1 - i);
    end

    exp_ext = $signed({2'b00, s1_exp_q});
    if (s1_raw_q[MW]) begin
      // carry out: shift right, keep the dropped bit in sticky
      norm_man = s1_raw_q[MW:1] | MW'(s1_raw_q[0]);
      exp_norm = exp_ext + XE_W'(1);
    end else begin
      norm_man = s1_raw_q[MW-1:0] << lz;
      exp_norm = exp_ext - $signed(XE_W'(lz));
    end

    // hidden bit clear after normalisation only when the raw sum was zero
    is_zero = ~norm_man[MW-1];

`ifdef FP_ADDSUB_RNE_EN
    round_inc = norm_man[2] & (norm_man[1] | norm_man[0] | norm_man[3]);
    mant_rnd  = {1'b0, norm_man[MW-1:3]} + MR_W'(round_inc);
    if (mant_rnd[MR_W-1]) begin
      frac    = mant_rnd[M_WIDTH:1];
      exp_fin = exp_norm + XE_W'(1);
    end else begin
      frac    = mant_rnd[M_WIDTH-1:0];
      exp_fin = exp_norm;
    end
`else
    frac    = norm_man[MW-2:3];
    exp_fin = exp_norm;
`endif

    norm_result  = {s1_sign_q, exp_fin[E_WIDTH-1:0], frac};
    norm_ovf     = 1'b0;
    norm_unf     = 1'b0;
    norm_inexact = |norm_man[2:0];

    if (s1_spc_q) begin
      norm_result  = s1_spc_val_q;
      norm_inexact = 1'b0;
    end else if (is_zero) begin
      norm_result  = '0;
      norm_inexact = 1'b0;
    end else if (exp_norm[XE_W-1] || (exp_norm == '0)) begin
      // below the normal range: flush, the whole nonzero mantissa is lost
      norm_result  = {s1_sign_q, {(E_WIDTH + M_WIDTH){1'b0}}};
      norm_unf     = 1'b1;
      norm_inexact = 1'b1;
    end else if (exp_fin >= EXP_MAX) begin
      norm_result = {s1_sign_q, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
      norm_ovf    = 1'b1;
    end
  end

  // Next-state for both pipeline stages
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_raw_d     = s1_raw_q;
    s1_sign_d    = s1_sign_q;
    s1_exp_d     = s1_exp_q;
    s1_spc_d     = s1_spc_q;
    s1_spc_val_d = s1_spc_val_q;
    s2_valid_d   = s2_valid_q;
    result_d     = result_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    inexact_d    = inexact_q;

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d  = norm_result;
        ovf_d     = norm_ovf;
        unf_d     = norm_unf;
        inexact_d = norm_inexact;
      end
    end

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_raw_d     = raw_in;
        s1_sign_d    = sign_in;
        s1_exp_d     = exp_in;
        s1_spc_d     = spc_case;
        s1_spc_val_d = spc_val;
      end
    end
  end

  // Pipeline registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_raw_q     <= '0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_spc_q     <= 1'b0;
      s1_spc_val_q <= '0;
      s2_valid_q   <= 1'b0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      inexact_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_raw_q     <= s1_raw_d;
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_spc_q     <= s1_spc_d;
      s1_spc_val_q <= s1_spc_val_d;
      s2_valid_q   <= s2_valid_d;
      result_q     <= result_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      inexact_q    <= inexact_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_norm_pipe.sv
// Directed bench for fp_addsub_norm_pipe (single precision), scoreboard-checked outputs.
module tb_fp_addsub_norm_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic        sign_a;
  logic [7:0]  exp_in;
  logic [26:0] man_a;
  logic [26:0] man_b;
  logic        spc_case;
  logic [31:0] spc_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_inexact;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_out    = 0;
  int   last_wait = 0;

  localparam logic [26:0] ONE   = 27'h4000000;  // 1.0
  localparam logic [26:0] ONE5  = 27'h6000000;  // 1.5
  localparam logic [26:0] P75   = 27'h3000000;  // 0.75
  localparam logic [26:0] ALL1G = 27'h7FFFFFC;  // 1.111..1 with G set

`ifdef FP_ADDSUB_RNE_EN
  localparam logic [31:0] R_ULP15 = 32'h3F800002;
  localparam logic [31:0] R_RCARRY = 32'h40000000;
  localparam logic [31:0] R_ROVF = 32'h7F800000;
  localparam logic        F_ROVF = 1'b1;
`else
  localparam logic [31:0] R_ULP15 = 32'h3F800001;
  localparam logic [31:0] R_RCARRY = 32'h3FFFFFFF;
  localparam logic [31:0] R_ROVF = 32'h7F7FFFFF;
  localparam logic        F_ROVF = 1'b0;
`endif

  fp_addsub_norm_pipe #(.E_WIDTH(8), .M_WIDTH(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .sign_a(sign_a), .exp_in(exp_in),
    .man_a(man_a), .man_b(man_b),
    .spc_case(spc_case), .spc_val(spc_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inexact(flag_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Present one beat and hold it until accepted; record its expected result
  task automatic send(input logic sub, input logic sa, input logic [7:0] e,
                      input logic [26:0] ma, input logic [26:0] mb,
                      input logic spc, input logic [31:0] sv,
                      input logic [31:0] er, input logic eo, input logic eu, input logic ei);
    int   n;
    exp_t x;
    op_sub = sub; sign_a = sa; exp_in = e; man_a = ma; man_b = mb;
    spc_case = spc; spc_val = sv; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    last_wait = n;
    if (in_ready) begin
      x.res = er; x.ovf = eo; x.unf = eu; x.inx = ei;
      sb.push_back(x);
      n_push++;
    end else begin
      check("send_timeout", {31'd0, in_ready}, 32'd1);
    end
    @(posedge clk);
    #1;
    if (n >= 100) in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    spc_case = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Compare every accepted output beat against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid && out_ready) begin
      n_out++;
      check("out_expected", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("ovf", {31'd0, flag_ovf}, {31'd0, e.ovf});
        check("unf", {31'd0, flag_unf}, {31'd0, e.unf});
        check("inexact", {31'd0, flag_inexact}, {31'd0, e.inx});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; op_sub = 1'b0; sign_a = 1'b0; exp_in = '0;
    man_a = '0; man_b = '0; spc_case = 1'b0; spc_val = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'd0, flag_ovf, flag_unf, flag_inexact}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1.0 + 1.0 with explicit latency check
    send(0, 0, 8'd127, ONE, ONE, 0, 32'd0, 32'h40000000, 0, 0, 0);
    idle();
    @(negedge clk);
    check("lat_cycle1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_cycle2", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    drain();

    // back-to-back stream: one beat per cycle
    send(1, 1, 8'd127, ONE5, ONE5, 0, 32'd0, 32'h00000000, 0, 0, 0);   // 1.5-1.5 -> +0
    send(1, 0, 8'd127, ONE, P75, 0, 32'd0, 32'h3E800000, 0, 0, 0);     // 1.0-0.75
    check("tput_1", last_wait, 32'd0);
    send(1, 0, 8'd127, P75, ONE, 0, 32'd0, 32'hBE800000, 0, 0, 0);     // swap, sign flips
    check("tput_2", last_wait, 32'd0);
    send(0, 0, 8'd254, ONE5, ONE5, 0, 32'd0, 32'h7F800000, 1, 0, 0);   // overflow
    send(0, 0, 8'd127, ONE, 27'd12, 0, 32'd0, R_ULP15, 0, 0, 1);       // 1.5 ulp
    send(0, 0, 8'd127, ONE, 27'd4, 0, 32'd0, 32'h3F800000, 0, 0, 1);   // 0.5 ulp tie
    send(1, 1, 8'd1, ONE, P75, 0, 32'd0, 32'h80000000, 0, 1, 1);       // underflow flush
    send(0, 0, 8'd127, ONE | 27'd1, ONE, 0, 32'd0, 32'h40000000, 0, 0, 1); // carry, sticky kept
    send(0, 0, 8'd127, ALL1G, 27'd0, 0, 32'd0, R_RCARRY, 0, 0, 1);     // rounding carry
    send(0, 0, 8'd254, ALL1G, 27'd0, 0, 32'd0, R_ROVF, F_ROVF, 0, 1);  // overflow via rounding
    check("tput_3", last_wait, 32'd0);
    idle();
    drain();

    // bypass interleaved between normal beats
    send(0, 0, 8'd127, ONE, ONE, 0, 32'd0, 32'h40000000, 0, 0, 0);
    send(0, 0, 8'd254, ONE5, ONE5, 1, 32'h7FC00000, 32'h7FC00000, 0, 0, 0);
    send(1, 0, 8'd127, ONE, P75, 0, 32'd0, 32'h3E800000, 0, 0, 0);
    idle();
    drain();

    // backpressure: 4 beats while downstream stalls
    out_ready = 1'b0;
    fork
      begin
        send(0, 0, 8'd127, ONE, ONE, 0, 32'd0, 32'h40000000, 0, 0, 0);
        send(1, 0, 8'd127, ONE, P75, 0, 32'd0, 32'h3E800000, 0, 0, 0);
        send(0, 0, 8'd254, ONE5, ONE5, 0, 32'd0, 32'h7F800000, 1, 0, 0);
        send(0, 0, 8'd127, ONE, 27'd4, 0, 32'd0, 32'h3F800000, 0, 0, 1);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_out_held", {31'd0, out_valid}, 32'd1);
        check("bp_result_held", result, 32'h40000000);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_out, n_push);

    // reset during a stall discards pending beats
    out_ready = 1'b0;
    send(0, 0, 8'd127, ONE, ONE, 0, 32'd0, 32'h40000000, 0, 0, 0);
    send(1, 0, 8'd127, ONE, P75, 0, 32'd0, 32'h3E800000, 0, 0, 0);
    idle();
    @(posedge clk);
    #1;
    check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b0;
    n_push = n_push - sb.size();
    sb.delete();
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale", {31'd0, out_valid}, 32'd0);
    end
    check("final_count", n_out, n_push);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_addsub_norm_pipe.md
Name: fp_addsub_norm_pipe

Overview:
Parametrised successor to the single-cycle mantissa adder stage in the FP add/sub datapath. It takes exponent-aligned mantissas with guard/round/sticky bits and performs a magnitude add or subtract with operand swap. It then normalises, rounds and packs an IEEE-style result. It is a 2-stage pipeline with valid/ready handshakes on both sides, sitting between the exponent-align stage and the result writeback.

Parameters:
E_WIDTH, 8, exponent width
M_WIDTH, 23, stored fraction width (hidden bit excluded)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept input
op_sub  in  1  effective operation: 0 = magnitude add, 1 = magnitude subtract
sign_a  in  1  sign of operand A
exp_in  in  E_WIDTH  common (larger) exponent, 1..2^E_WIDTH-2
man_a  in  M_WIDTH+4  {hidden, fraction, G, R, S} of A
man_b  in  M_WIDTH+4  {hidden, fraction, G, R, S} of B, already aligned to exp_in
spc_case  in  1  special-case bypass (NaN/Inf/zero resolved upstream)
spc_val  in  1+E_WIDTH+M_WIDTH  packed bypass result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  1+E_WIDTH+M_WIDTH  packed {sign, exp, fraction}
flag_ovf  out  1  overflow to infinity
flag_unf  out  1  underflow flushed to zero
flag_inexact  out  1  any nonzero G/R/S discarded

Behaviour:
- Reset: rst low asynchronously clears both stage valid bits, result, and all flags. out_valid=0. in_ready=1 after reset.
- Handshake: a beat is transferred when valid and ready are both high on a clk edge. Each stage holds its data until it advances.
  - stage2 advances when out_ready is high or stage2 is empty.
  - in_ready = stage1 empty or stage1 advancing, with no combinational path from in_valid.
  - Latency is 2 cycles with no stall. Throughput is 1 beat/cycle. Order is preserved. No beat is dropped or duplicated under any out_ready pattern.
- Stage1 (add/sub):
  - op_sub=0: raw = man_a + man_b, width M_WIDTH+5 including carry; sign = sign_a.
  - op_sub=1: if man_b > man_a, raw = man_b - man_a and sign = ~sign_a; otherwise raw = man_a - man_b and sign = sign_a.
  - Register raw, sign, exp_in and the bypass fields.
- Stage2 (normalise):
  - Carry set: shift right by 1, OR the dropped bit into S, exp+1.
  - Otherwise: count leading zeros lz below the carry, shift left by lz with zeros in, exp-lz.
  - raw==0: result is +0 (sign 0, exp 0, frac 0), flag_inexact=0.
  - exp-lz <= 0: flush to signed zero, flag_unf=1.
  - Resulting exp >= 2^E_WIDTH-1 (including after rounding carry): result {sign, all-ones, 0}, flag_ovf=1.
- Inexact: flag_inexact = G|R|S after normalisation, or any bit lost during flush.
- Flags are per-result: valid only with out_valid and held while stalled.
- spc_case beat: result=spc_val, all flags 0. It follows the same latency and handshake as a normal beat.
- Reset mid-stall: pending beats are discarded and no output appears.

Optional Feature:
FP_ADDSUB_RNE_EN
- Defined: round-to-nearest-even after normalisation. Increment when G & (R | S | LSB).
  - A fraction carry-out from rounding shifts right 1 and increments exp, and may trigger overflow.
- Undefined: truncate (round toward zero). No incrementer is present.
- flag_inexact behaves identically in both builds.

Test Plan:
- 1.0+1.0: exp_in=127, man_a=man_b=hidden only, op_sub=0 -> result 0x40000000 after 2 cycles, flags 0.
- 1.5-1.5: op_sub=1 -> result 0x00000000, sign 0, flags 0. Then 1.0-0.75 (man_b aligned 0.75) -> 0x3E800000.
- Overflow: exp_in=254, 1.5+1.5 -> 0x7F800000 (sign 0), flag_ovf=1.
- Rounding with A=1.0, B=1.5 ulp:
  - RNE build -> 0x3F800002, flag_inexact=1.
  - Truncate build -> 0x3F800001, flag_inexact=1.
  - Tie case B=0.5 ulp -> 0x3F800000 in both builds.
- Backpressure: 4 back-to-back beats with out_ready=0 for 3 cycles -> in_ready drops once both stages are full. After release, all 4 results emerge in order with no loss or duplication.
- Bypass: spc_case=1, spc_val=0x7FC00000 interleaved between normal beats -> 0x7FC00000 emitted in order with flags 0. Assert rst mid-stall -> out_valid=0 immediately and no stale output afterwards.
